spi_byte_target: RTL and testbench

// - SPI mode-0 target (CPOL=0, CPHA=0), MSB first, fully in the CLK domain.
// - Oversamples SCK, MOSI and NORM_CS_N. Delivers each received byte as a one-cycle strobe.

---
 rtl/spi_byte_target_pkg.sv | 12 +
 rtl/spi_byte_target_sync_2ff.sv | 24 ++
 rtl/spi_byte_target.sv | 155 +++++++++++++++
 tb/tb_spi_byte_target.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_target_pkg.sv
// Shared widths and state encoding for the SPI byte target.
package spi_byte_target_pkg;

    localparam int unsigned SPI_BYTE_W   = 8;
    localparam int unsigned SPI_BITCNT_W = 3;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StActive = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_byte_target_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset value.
module spi_byte_target_sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous pin into the CLK domain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_byte_target.sv
// SPI mode-0 target, MSB first, oversampled entirely in the CLK domain.
// Received bytes leave as a one-cycle strobe; transmit bytes come from a
// one-entry valid/ready holding register, falling back to DEFAULT_TX when empty.
module spi_byte_target
    import spi_byte_target_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCK,
    input  logic                  MOSI,
    input  logic                  NORM_CS_N,
    output logic                  MISO,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  cs_active
);

    logic                    sck_s;
    logic                    sck_d;
    logic                    mosi_s;
    logic                    cs_n_s;
    spi_state_e              state;
    logic [SPI_BITCNT_W-1:0] bit_cnt;
    logic [SPI_BYTE_W-2:0]   rx_shift;
    logic [SPI_BYTE_W-1:0]   rx_next;
    logic [SPI_BYTE_W-1:0]   tx_shift;
    logic [SPI_BYTE_W-1:0]   hold_data;
    logic                    hold_full;
    logic [SPI_BYTE_W-1:0]   load_byte;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    tx_load;
    logic                    tx_take;

    spi_byte_target_sync_2ff #(.RESET_VAL(1'b0)) u_sync_sck (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (SCK),
        .q     (sck_s)
    );

    spi_byte_target_sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (MOSI),
        .q     (mosi_s)
    );

    spi_byte_target_sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs_n (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (NORM_CS_N),
        .q     (cs_n_s)
    );

    // Delayed copy of synchronised SCK for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_d <= 1'b0;
        end else begin
            sck_d <= sck_s;
        end
    end

    assign cs_active = ~cs_n_s;
    assign tx_ready  = ~hold_full;
    // tx_shift is zero whenever the FSM is idle, so MISO needs no extra gating.
    assign MISO      = tx_shift[SPI_BYTE_W-1];

    // Edge strobes, byte-load decision and handshake acceptance.
    always_comb begin
        sck_rise  = sck_s & ~sck_d;
        sck_fall  = ~sck_s & sck_d;
        rx_next   = {rx_shift, mosi_s};
        load_byte = hold_full ? hold_data : DEFAULT_TX;
        tx_load   = 1'b0;
        if (state == StIdle) begin
            tx_load = cs_active;
        end else if (cs_active && sck_fall && (bit_cnt == '0)) begin
            tx_load = 1'b1;
        end
        // A load and a transfer in the same cycle: the load sees the empty register.
        tx_take   = tx_valid & ~hold_full;
    end

    // Transmit holding register: filled by the handshake, drained by byte loads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_load && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_take) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

    // Frame FSM with shift registers and registered strobes; CS changes win over SCK edges.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= StIdle;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cs_active) begin
                        state       <= StActive;
                        bit_cnt     <= '0;
                        tx_shift    <= load_byte;
                        tx_underrun <= ~hold_full;
                    end
                end
                StActive: begin
                    if (!cs_active) begin
                        // Abandon any partial byte; the holding register is untouched.
                        state    <= StIdle;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_next[SPI_BYTE_W-2:0];
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == '1) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                        end else begin
                            tx_shift    <= load_byte;
                            tx_underrun <= ~hold_full;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_target.sv
// Self-checking bench for spi_byte_target: bit-banged SPI master plus an rx scoreboard.
module tb_spi_byte_target;

    localparam int HALF = 10; // SCK half period in CLK cycles (SCK = CLK/20)

    logic       CLK;
    logic       RST_N;
    logic       SCK;
    logic       MOSI;
    logic       NORM_CS_N;
    logic       MISO;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       cs_active;

    int         n_cmp;
    int         n_err;
    int         n_underrun;
    int         u0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] rx_exp;

    spi_byte_target #(.DEFAULT_TX(8'hFF)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SCK         (SCK),
        .MOSI        (MOSI),
        .NORM_CS_N   (NORM_CS_N),
        .MISO        (MISO),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .cs_active   (cs_active)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every rx_valid pops one expected byte; tx_underrun pulses are counted.
    always @(negedge CLK) begin
        if (tx_underrun) n_underrun++;
        if (rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                check_eq("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                rx_exp = rx_exp_q.pop_front();
                check_eq("rx_data", {24'd0, rx_data}, {24'd0, rx_exp});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic offer_tx(input logic [7:0] b);
        @(negedge CLK);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge CLK);
        tx_valid = 1'b0;
        check_eq("tx_ready_after_offer", tx_ready, 1'b0);
    endtask

    // One byte; on the final byte of a frame SCK falls together with CS release.
    // With offer set, a byte is offered in exactly the CLK cycle of the boundary load.
    task automatic spi_byte(input logic [7:0] mosi_b, input logic [7:0] miso_exp, input bit last,
                            input bit offer, input logic [7:0] offer_b);
        logic [7:0] got;
        got = '0;
        rx_exp_q.push_back(mosi_b);
        for (int i = 7; i >= 0; i--) begin
            MOSI = mosi_b[i];
            repeat (HALF) @(negedge CLK);
            SCK    = 1'b1;
            got[i] = MISO;
            repeat (HALF) @(negedge CLK);
            SCK = 1'b0;
            if (i == 0 && last) NORM_CS_N = 1'b1;
        end
        check_eq("miso_byte", {24'd0, got}, {24'd0, miso_exp});
        if (offer) begin
            // Pin edge at t; synchronised fall is acted on at the posedge t+25.
            @(negedge CLK);
            @(negedge CLK);
            tx_valid = 1'b1;
            tx_data  = offer_b;
            @(negedge CLK);
            tx_valid = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input logic [23:0] mosi_w, input logic [23:0] miso_w,
                             input int offer_idx, input logic [7:0] offer_b);
        NORM_CS_N = 1'b0;
        repeat (HALF) @(negedge CLK);
        check_eq("cs_active_on", cs_active, 1'b1);
        check_eq("tx_ready_after_load", tx_ready, 1'b1);
        for (int k = 0; k < n; k++) begin
            spi_byte(mosi_w[8*k +: 8], miso_w[8*k +: 8], k == n - 1, k == offer_idx, offer_b);
        end
        repeat (2 * HALF) @(negedge CLK);
        check_eq("cs_active_off", cs_active, 1'b0);
        check_eq("rx_all_delivered", rx_exp_q.size(), 0);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            repeat (HALF) @(negedge CLK);
            SCK = 1'b1;
            repeat (HALF) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_miso"}, MISO, 1'b0);
        check_eq({phase, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check_eq({phase, "_rx_valid"}, rx_valid, 1'b0);
        check_eq({phase, "_tx_ready"}, tx_ready, 1'b1);
        check_eq({phase, "_tx_underrun"}, tx_underrun, 1'b0);
        check_eq({phase, "_cs_active"}, cs_active, 1'b0);
    endtask

    task automatic preload_frame_a5_3c();
        offer_tx(8'hA5);
        u0 = n_underrun;
        spi_frame(1, {16'h0, 8'h3C}, {16'h0, 8'hA5}, -1, 8'h00);
        check_eq("a5_underruns", n_underrun - u0, 0);
        check_eq("a5_rx_held", {24'd0, rx_data}, 32'h3C);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        n_underrun = 0;
        RST_N      = 1'b0;
        SCK        = 1'b0;
        MOSI       = 1'b0;
        NORM_CS_N  = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;

        repeat (3) @(negedge CLK);
        check_reset_outputs("in_reset");
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check_reset_outputs("idle");

        // Preloaded A5 out, 3C in.
        preload_frame_a5_3c();

        // Two bytes with an empty buffer.
        u0 = n_underrun;
        spi_frame(2, {8'h0, 8'h80, 8'h01}, {8'h0, 8'hFF, 8'hFF}, -1, 8'h00);
        check_eq("empty_underruns", n_underrun - u0, 2);

        // Frame aborted after 5 SCK cycles, then a full C3 frame.
        u0 = n_underrun;
        NORM_CS_N = 1'b0;
        repeat (HALF) @(negedge CLK);
        spi_bits(8'hF0, 5);
        repeat (HALF) @(negedge CLK);
        NORM_CS_N = 1'b1;
        repeat (2 * HALF) @(negedge CLK);
        check_eq("abort_rx_held", {24'd0, rx_data}, 32'h80);
        spi_frame(1, {16'h0, 8'hC3}, {16'h0, 8'hFF}, -1, 8'h00);
        check_eq("abort_underruns", n_underrun - u0, 2);

        // 5A offered in the cycle of the byte-1/byte-2 boundary load.
        offer_tx(8'h11);
        u0 = n_underrun;
        spi_frame(3, {8'h0F, 8'h69, 8'h96}, {8'h5A, 8'hFF, 8'h11}, 0, 8'h5A);
        check_eq("boundary_underruns", n_underrun - u0, 1);

        // Reset asserted mid-byte, away from any clock edge.
        NORM_CS_N = 1'b0;
        repeat (HALF) @(negedge CLK);
        offer_tx(8'h66);
        spi_bits(8'h00, 3);
        MOSI = 1'b1;
        repeat (HALF / 2) @(negedge CLK);
        SCK = 1'b1;
        check_eq("pre_reset_miso", MISO, 1'b1);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("async_reset");
        SCK       = 1'b0;
        MOSI      = 1'b0;
        NORM_CS_N = 1'b1;
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        repeat (HALF) @(negedge CLK);
        check_reset_outputs("post_reset");

        // Following frame behaves as the first.
        preload_frame_a5_3c();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
